// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter/receiver pair.
// Holds the default frame format, the receiver state encoding and a parity helper.
package serial_pkg;

  localparam int unsigned CLK_DIVIDER = 5;
  localparam int unsigned DATA_LEN    = 8;
  localparam int unsigned PARITY      = 1;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned STOP_BIT    = 1;

  // Receiver states; enumerators are prefixed so they do not clash with PARITY above.
  typedef enum logic [2:0] {
    RxIdle   = 3'd0,
    RxStart  = 3'd1,
    RxData   = 3'd2,
    RxParity = 3'd3,
    RxStop   = 3'd4
  } rx_state_t;

  // Parity bit for the low 'len' bits of 'data': XOR for even parity, inverted for odd.
  function automatic logic calc_parity(input logic [31:0] data, input int unsigned len,
                                       input logic even);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < len) p = p ^ data[i];
    end
    return even ? p : ~p;
  endfunction

endpackage

// File: rtl/serial_line_sync.sv
// Input synchronizer for the serial line.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset (flops reset to idle-high)
//   line_i  asynchronous serial input
//   line_o  synchronized line
//   fall_o  high for the cycle in which line_o is 0 and was 1 the cycle before
module serial_line_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], line_i};
    prev_d = sync_q[SyncStages-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_o = sync_q[SyncStages-1];
  assign fall_o = ~line_o & prev_q;

endmodule

// File: rtl/serial_receiver.sv
// Serial frame receiver: start bit, DataLen data bits LSB first, optional parity,
// StopBit stop bits, each ClkDivider cycles long. Recovered bytes land in a
// single-entry output register with a valid/ready handshake.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   SerialLine   serial input, idle high
//   DataOutput   held byte; DataValid marks it unconsumed; DataReady accepts it
//   ParityError  parity status of the held byte
//   FrameError   one-cycle pulse on a low stop sample
//   Overrun      one-cycle pulse when a completed frame is dropped
//   Busy         receiver is not idle
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned ClkDivider = CLK_DIVIDER,
  parameter int unsigned DataLen    = DATA_LEN,
  parameter int unsigned Parity     = PARITY,
  parameter int unsigned ParityEven = PARITY_EVEN,
  parameter int unsigned StopBit    = STOP_BIT,
  parameter int unsigned SyncStages = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SerialLine,
  output logic [DataLen-1:0] DataOutput,
  output logic               DataValid,
  input  logic               DataReady,
  output logic               ParityError,
  output logic               FrameError,
  output logic               Overrun,
  output logic               Busy
);

  localparam int unsigned HalfBit = ClkDivider / 2;
  localparam int unsigned DivW    = $clog2(ClkDivider);
  localparam int unsigned BitW    = $clog2(DataLen + Parity + StopBit + 1);

  logic line_s, line_fall;

  serial_line_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .line_i(SerialLine),
    .line_o(line_s),
    .fall_o(line_fall)
  );

  rx_state_t          state_q, state_d;
  logic [DivW-1:0]    div_q, div_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [DataLen-1:0] shift_q, shift_d;
  logic               perr_pend_q, perr_pend_d;
  logic               frame_err_q, frame_err_d;
  logic               done;

  logic [DataLen-1:0] data_out_q, data_out_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               overrun_q, overrun_d;

  // div_q counts 0..ClkDivider-1 within a bit; a sample is taken when it hits the
  // last count, so the first data sample lands ClkDivider cycles after the start sample.
  logic start_tick, bit_tick;
  assign start_tick = (div_q == DivW'(HalfBit - 1));
  assign bit_tick   = (div_q == DivW'(ClkDivider - 1));

  always_comb begin
    state_d     = state_q;
    div_d       = div_q + DivW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    frame_err_d = 1'b0;
    done        = 1'b0;
    case (state_q)
      RxIdle: begin
        div_d = '0;
        if (line_fall) begin
          state_d     = RxStart;
          bit_d       = '0;
          perr_pend_d = 1'b0;
        end
      end
      RxStart: begin
        if (start_tick) begin
          div_d   = '0;
          state_d = line_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (bit_tick) begin
          div_d                = '0;
          shift_d              = shift_q >> 1;
          shift_d[DataLen-1]   = line_s;
          if (bit_q == BitW'(DataLen - 1)) begin
            bit_d   = '0;
            state_d = (Parity != 0) ? RxParity : RxStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      RxParity: begin
        if (bit_tick) begin
          div_d   = '0;
          state_d = RxStop;
          if (line_s != calc_parity(32'(shift_q), DataLen, ParityEven != 0)) begin
            perr_pend_d = 1'b1;
          end
        end
      end
      RxStop: begin
        if (bit_tick) begin
          div_d = '0;
          if (!line_s) begin
            frame_err_d = 1'b1;
            state_d     = RxIdle;
          end else if (bit_q == BitW'(StopBit - 1)) begin
            done    = 1'b1;
            state_d = RxIdle;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  // A completing frame loads if the register is empty or being drained this cycle.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    overrun_d  = 1'b0;
    if (valid_q && DataReady) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || DataReady) begin
        data_out_d = shift_q;
        perr_d     = perr_pend_q;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RxIdle;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      frame_err_q <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      frame_err_q <= frame_err_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign DataOutput  = data_out_q;
  assign DataValid   = valid_q;
  assign ParityError = perr_q;
  assign FrameError  = frame_err_q;
  assign Overrun     = overrun_q;
  assign Busy        = (state_q != RxIdle);

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Downstream partner of the serial transmitter chain; consumes its SerialLine and recovers bytes.
- Frame: 1 start bit (0), DataLen data bits LSB first, optional parity bit, StopBit stop bits (1); each bit lasts ClkDivider clk cycles.
- Recovered bytes go to a single-entry output register with a valid/ready handshake, plus parity, framing and overrun status.

Parameters:
- ClkDivider, 5: clk cycles per bit; must be ≥3.
- DataLen, 8: data bits per frame.
- Parity, 1: 1 means a parity bit follows the data.
- ParityEven, 1: 1 means even parity (bit = XOR of data), 0 means odd.
- StopBit, 1: number of stop bits checked.
- SyncStages, 2: input synchronizer depth; must be ≥2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- SerialLine  in  1  serial input, idle high.
- DataOutput  out  DataLen  received data.
- DataValid  out  1  DataOutput holds an unconsumed byte.
- DataReady  in  1  consumer accepts when high together with DataValid.
- ParityError  out  1  parity status of the held byte.
- FrameError  out  1  one-cycle pulse when the stop bit is sampled low.
- Overrun  out  1  one-cycle pulse when a completed frame is dropped.
- Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset clears all state and outputs: DataOutput=0, DataValid=0, ParityError=0, FrameError=0, Overrun=0, Busy=0, state=IDLE.
- Reset forces synchronizer flops and the previous-line register to 1.
- Reset mid-frame abandons the frame and raises no flags.
- line_s: SerialLine after SyncStages flops.
- Falling edge: line_s=0 and previous line_s=1.
- D: the cycle a falling edge is seen in IDLE.
- HalfBit = ClkDivider/2, integer division (2 at defaults).
- States: IDLE → START → DATA → PARITY (only if Parity=1) → STOP → IDLE.
- IDLE: on a falling edge, go to START with bit counter cleared.
- START: sample line_s at D+HalfBit.
  - If 1: false start; return to IDLE with no flags.
  - If 0: go to DATA.
- Sample n (n=1..DataLen) is taken at D+HalfBit+n*ClkDivider; sample n goes into data bit n-1.
- PARITY: sample at D+HalfBit+(DataLen+1)*ClkDivider.
  - Expected value: XOR of data if ParityEven, else its inverse.
  - Mismatch sets the pending parity error.
- STOP: each stop bit is sampled ClkDivider after the previous sample.
  - Any stop sample=0: FrameError pulses the next cycle, the byte is discarded, return to IDLE.
  - A new frame needs a fresh high→low edge.
- Delivery: after a good final stop sample, DataValid rises the next cycle. At defaults that is D+53.
  - DataOutput and ParityError are loaded in the same cycle.
  - A byte with a parity error is still delivered, with ParityError=1.
- DataValid and DataOutput hold until a clk edge with DataReady=1. DataValid then drops, unless a new byte loads in that same cycle.
- Completion while DataValid=1 and DataReady=0: the new byte is dropped, Overrun pulses one cycle, the held byte is unchanged.
- Completion in the same cycle as an accept: the new byte loads, no overrun.
- Return to IDLE is immediate after the last stop sample, so back-to-back frames at the transmitter's rate are received.
- Bit counter width: $clog2(DataLen+Parity+StopBit+1). Divider counter width: $clog2(ClkDivider).

Decomposition:
- Shared package serial_pkg holds:
  - CLK_DIVIDER, DATA_LEN, PARITY, PARITY_EVEN, STOP_BIT, shared with the transmitter.
  - The rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - A parity function.
- One sub-module, serial_line_sync: SyncStages flop chain reset to 1, registered previous value, falling-edge strobe output.
- FSM, counters and output register live in serial_receiver.

Test Plan:
- Frame 0xA5 (even parity bit 0, stop 1), DataReady=1 → DataValid one cycle at D+53, DataOutput=0xA5, ParityError=0.
- Frame 0x07 with parity bit sent as 0 (correct value 1) → DataOutput=0x07, ParityError=1, FrameError=0.
- Frame 0x3C with stop bit driven 0 → FrameError pulse, DataValid stays 0; next valid frame 0x11 is received correctly.
- One-cycle low glitch on an idle line → false start, back to IDLE, no output or flags.
- Frames 0x12 then 0x34 with DataReady=0 → DataOutput holds 0x12, Overrun pulses at the second completion; after DataReady=1, DataValid=0.
- rst asserted during data bit 4 of a frame → all outputs 0, Busy=0; next frame 0x5A received correctly.
- Loopback: write 0x3C to the transmitter chain at ClkDivider=5, SerialLine wired to serial_receiver → DataOutput=0x3C, no error flags.
